layer_mixer: RTL and testbench
==============================

Name: layer_mixer

Overview:
- Per-pixel compositor and arbiter for the four gazou-gen layer generators: layer_a, layer_b, layer_c and layer_d (background).
- Each cycle it selects one layer's RGB from a programmable priority order and per-layer enable mask, then applies a global fade.
- Drives the registered pixel stream to the display output stage.
- Configuration writes from the CPU bus are double-buffered and take effect only at frame start, so no mid-frame tearing.

Parameters:
- NL, 4, number of layer inputs (fixed 4; the priority field is 4 x 2 bits).
- CW, 8, colour component width.

Ports:
- clk  in  1  pixel clock
- rstb  in  1  reset
- h_c_en  in  1  active-video qualifier, aligned with the layer outputs
- frame_start  in  1  one-cycle pulse at the start of each frame; applies the pending configuration
- lay_en  in  4  per-layer gen_da_en; bit i = layer i
- lay_r  in  32  layer i red at [8i+7:8i]
- lay_g  in  32  layer i green at [8i+7:8i]
- lay_b  in  32  layer i blue at [8i+7:8i]
- cfg_we  in  1  config write strobe
- cfg_addr  in  2  config register select
- cfg_wdata  in  8  config write data
- cfg_rdata  out  8  pending value of the addressed register, registered
- cfg_pending  out  1  a write is waiting for frame_start
- out_en  out  1  pixel valid
- out_r  out  8  mixed red
- out_g  out  8  mixed green
- out_b  out  8  mixed blue
- out_src  out  3  winning layer 0-3; 4 = background fill

Behaviour:
- Reset: asynchronous via rstb, active-low; clock clk. All outputs 0 under reset.
- Config registers reset to these values, in both the pending and active copies:
  - 0 ENABLE [3:0] = 4'hF
  - 1 PRIO = 8'hE4 (slot0 = layer0 highest ... slot3 = layer3 lowest)
  - 2 FADE = 8'hFF
  - 3 BGLEVEL = 8'h00
- Unused ENABLE bits [7:4] write-ignored, read 0.
- Writes: cfg_we updates the pending copy next edge and sets cfg_pending.
- cfg_rdata is the pending copy at cfg_addr, one cycle latency.
- Apply: frame_start copies pending to active and clears cfg_pending.
- Write and frame_start in the same cycle:
  - active receives the pre-write pending values;
  - the new write lands in pending;
  - cfg_pending stays 1;
  - it is applied at the next frame_start.
- Stage 1, registered:
  - candidate for slot k = PRIO[2k+1:2k];
  - winner = lowest slot k whose candidate layer has lay_en = 1 and ENABLE = 1;
  - duplicate ids in PRIO are legal; a layer absent from PRIO never wins;
  - no winner → colour (BGLEVEL, BGLEVEL, BGLEVEL) with src 4;
  - h_c_en = 0 → colour 0, src 0, valid 0.
- Stage 2, registered:
  - out_c = (c * (FADE + 1)) >> 8, computed as 8x9-bit product bits [15:8];
  - FADE = 255 gives identity, FADE = 0 gives c >> 8 = 0;
  - out_en and out_src are pipelined alongside.
- Latency: inputs to outputs is exactly 2 clk. Full throughput, no stalls.
- Active config is sampled in stage 1, so a frame_start takes effect for the pixel presented in the same cycle as frame_start + 1.
- rstb asserted mid-frame: pipeline and config return to reset values immediately; no partial pixel is emitted.

Decomposition:
- Shared package, layer_mix_pkg:
  - register addresses CFG_ENABLE = 0, CFG_PRIO = 1, CFG_FADE = 2, CFG_BGLEVEL = 3;
  - reset constants;
  - SRC_BG = 3'd4.
- One natural sub-module: layer_mix_cfg, holding the pending/active register file, the frame_start apply logic and readback.
- Priority select and fade stay in the top level.

Test Plan:
- Reset defaults, all lay_en = 1, h_c_en = 1, layer0 = (10,20,30) → 2 cycles later out = (10,20,30), out_src = 0, out_en = 1.
- Write PRIO = 8'h1B, no frame_start → output unchanged and cfg_pending = 1. Pulse frame_start → layer3 wins, cfg_pending = 0.
- ENABLE = 0, BGLEVEL = 8'h40, applied → out = (64,64,64), out_src = 4. Then h_c_en = 0 → out = 0, out_en = 0 two cycles later.
- FADE = 8'h7F, layer colour (200,100,255) → out = (100,50,127). FADE = 0 → out = 0 with out_en = 1.
- cfg_we writing FADE = 8'h00 in the same cycle as frame_start → no change this frame, cfg_pending = 1; applied at the next frame_start.
- Assert rstb mid-stream with traffic → outputs 0 immediately. Config reads back 0F/E4/FF/00 after release.

Source files
------------

// File: rtl/layer_mix_pkg.sv
// Shared types, register map and reset constants for the layer mixer.
// Also holds the fade multiply and register readback helpers.
package layer_mix_pkg;

    localparam int NL = 4;
    localparam int CW = 8;

    typedef enum logic [1:0] {
        CFG_ENABLE  = 2'd0,
        CFG_PRIO    = 2'd1,
        CFG_FADE    = 2'd2,
        CFG_BGLEVEL = 2'd3
    } cfg_addr_e;

    localparam logic [NL-1:0]   RST_ENABLE  = 4'hF;
    localparam logic [2*NL-1:0] RST_PRIO    = 8'hE4;
    localparam logic [CW-1:0]   RST_FADE    = 8'hFF;
    localparam logic [CW-1:0]   RST_BGLEVEL = 8'h00;

    localparam logic [2:0] SRC_BG = 3'd4;

    typedef struct packed {
        logic [NL-1:0]   enable;
        logic [2*NL-1:0] prio;
        logic [CW-1:0]   fade;
        logic [CW-1:0]   bglevel;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{
        enable:  RST_ENABLE,
        prio:    RST_PRIO,
        fade:    RST_FADE,
        bglevel: RST_BGLEVEL
    };

    function automatic logic [7:0] cfg_read(input cfg_t c, input logic [1:0] addr);
        logic [7:0] r;
        r = '0;
        case (addr)
            CFG_ENABLE:  r = {4'h0, c.enable};
            CFG_PRIO:    r = c.prio;
            CFG_FADE:    r = c.fade;
            CFG_BGLEVEL: r = c.bglevel;
            default:     r = '0;
        endcase
        return r;
    endfunction

    // Scales by (fade + 1) / 256 so that 255 is an exact identity.
    function automatic logic [CW-1:0] fade_scale(input logic [CW-1:0] c, input logic [CW-1:0] fade);
        logic [CW:0]   f9;
        logic [2*CW:0] prod;
        f9   = {1'b0, fade} + (CW+1)'(1);
        prod = {{(CW+1){1'b0}}, c} * {{CW{1'b0}}, f9};
        return prod[2*CW-1:CW];
    endfunction

endpackage

// File: rtl/layer_mix_cfg.sv
// Double-buffered configuration registers: CPU writes land in the pending copy,
// frame_start moves pending into the active copy used by the pixel pipeline.
module layer_mix_cfg
    import layer_mix_pkg::*;
(
    input  logic       clk,
    input  logic       rstb,
    input  logic       frame_start_i,
    input  logic       we_i,
    input  logic [1:0] addr_i,
    input  logic [7:0] wdata_i,
    output cfg_t       active_o,
    output logic [7:0] rdata_o,
    output logic       pending_o
);

    cfg_t       pending_q, pending_d;
    cfg_t       active_q,  active_d;
    logic       flag_q,    flag_d;
    logic [7:0] rdata_q,   rdata_d;

    always_comb begin
        pending_d = pending_q;
        if (we_i) begin
            case (addr_i)
                CFG_ENABLE:  pending_d.enable  = wdata_i[NL-1:0];
                CFG_PRIO:    pending_d.prio    = wdata_i;
                CFG_FADE:    pending_d.fade    = wdata_i;
                CFG_BGLEVEL: pending_d.bglevel = wdata_i;
                default:     pending_d = pending_q;
            endcase
        end

        // Active takes the pre-write pending value, so a write colliding with
        // frame_start stays pending until the following frame.
        active_d = frame_start_i ? pending_q : active_q;

        flag_d = flag_q;
        if (we_i)               flag_d = 1'b1;
        else if (frame_start_i) flag_d = 1'b0;

        rdata_d = cfg_read(pending_q, addr_i);
    end

    // NOTE: state registers use non-blocking assignments only; all next-state
    // logic lives in the always_comb above so every register has one driver.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pending_q <= CFG_RESET;
            active_q  <= CFG_RESET;
            flag_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
            flag_q    <= flag_d;
            rdata_q   <= rdata_d;
        end
    end

    assign active_o  = active_q;
    assign rdata_o   = rdata_q;
    assign pending_o = flag_q;

endmodule

// File: rtl/layer_mixer.sv
// Per-pixel layer compositor: priority select (stage 1) followed by a global
// fade (stage 2), two clocks from layer inputs to the output pixel.
module layer_mixer
    import layer_mix_pkg::*;
(
    input  logic             clk,
    input  logic             rstb,
    input  logic             h_c_en,
    input  logic             frame_start,
    input  logic [NL-1:0]    lay_en,
    input  logic [NL*CW-1:0] lay_r,
    input  logic [NL*CW-1:0] lay_g,
    input  logic [NL*CW-1:0] lay_b,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [7:0]       cfg_wdata,
    output logic [7:0]       cfg_rdata,
    output logic             cfg_pending,
    output logic             out_en,
    output logic [CW-1:0]    out_r,
    output logic [CW-1:0]    out_g,
    output logic [CW-1:0]    out_b,
    output logic [2:0]       out_src
);

    cfg_t act;

    layer_mix_cfg u_cfg (
        .clk          (clk),
        .rstb         (rstb),
        .frame_start_i(frame_start),
        .we_i         (cfg_we),
        .addr_i       (cfg_addr),
        .wdata_i      (cfg_wdata),
        .active_o     (act),
        .rdata_o      (cfg_rdata),
        .pending_o    (cfg_pending)
    );

    logic          win_found;
    logic [1:0]    win_idx;
    logic [1:0]    cand;

    logic          s1_en_q,   s1_en_d;
    logic [2:0]    s1_src_q,  s1_src_d;
    logic [CW-1:0] s1_r_q,    s1_r_d;
    logic [CW-1:0] s1_g_q,    s1_g_d;
    logic [CW-1:0] s1_b_q,    s1_b_d;
    logic [CW-1:0] s1_fade_q;

    logic          s2_en_q;
    logic [2:0]    s2_src_q;
    logic [CW-1:0] s2_r_q, s2_g_q, s2_b_q;

    // Lowest slot whose layer is both producing data and enabled wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NL; k++) begin
            cand = act.prio[2*k +: 2];
            if (!win_found && lay_en[cand] && act.enable[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        s1_en_d  = 1'b0;
        s1_src_d = '0;
        s1_r_d   = '0;
        s1_g_d   = '0;
        s1_b_d   = '0;
        if (h_c_en) begin
            s1_en_d = 1'b1;
            if (win_found) begin
                s1_src_d = {1'b0, win_idx};
                s1_r_d   = lay_r[{win_idx, 3'b000} +: CW];
                s1_g_d   = lay_g[{win_idx, 3'b000} +: CW];
                s1_b_d   = lay_b[{win_idx, 3'b000} +: CW];
            end else begin
                s1_src_d = SRC_BG;
                s1_r_d   = act.bglevel;
                s1_g_d   = act.bglevel;
                s1_b_d   = act.bglevel;
            end
        end
    end

    // Fade is captured with the pixel so a whole pixel uses one configuration.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_en_q   <= 1'b0;
            s1_src_q  <= '0;
            s1_r_q    <= '0;
            s1_g_q    <= '0;
            s1_b_q    <= '0;
            s1_fade_q <= '0;
            s2_en_q   <= 1'b0;
            s2_src_q  <= '0;
            s2_r_q    <= '0;
            s2_g_q    <= '0;
            s2_b_q    <= '0;
        end else begin
            s1_en_q   <= s1_en_d;
            s1_src_q  <= s1_src_d;
            s1_r_q    <= s1_r_d;
            s1_g_q    <= s1_g_d;
            s1_b_q    <= s1_b_d;
            s1_fade_q <= act.fade;
            s2_en_q   <= s1_en_q;
            s2_src_q  <= s1_src_q;
            s2_r_q    <= fade_scale(s1_r_q, s1_fade_q);
            s2_g_q    <= fade_scale(s1_g_q, s1_fade_q);
            s2_b_q    <= fade_scale(s1_b_q, s1_fade_q);
        end
    end

    assign out_en  = s2_en_q;
    assign out_src = s2_src_q;
    assign out_r   = s2_r_q;
    assign out_g   = s2_g_q;
    assign out_b   = s2_b_q;

endmodule

// File: tb/tb_layer_mixer.sv
// Directed self-checking bench for layer_mixer: inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_layer_mixer;

    logic        clk = 1'b0;
    logic        rstb;
    logic        h_c_en;
    logic        frame_start;
    logic [3:0]  lay_en;
    logic [31:0] lay_r, lay_g, lay_b;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic [7:0]  cfg_rdata;
    logic        cfg_pending;
    logic        out_en;
    logic [7:0]  out_r, out_g, out_b;
    logic [2:0]  out_src;

    int n_cmp = 0;
    int n_bad = 0;

    layer_mixer dut (
        .clk        (clk),
        .rstb       (rstb),
        .h_c_en     (h_c_en),
        .frame_start(frame_start),
        .lay_en     (lay_en),
        .lay_r      (lay_r),
        .lay_g      (lay_g),
        .lay_b      (lay_b),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .cfg_pending(cfg_pending),
        .out_en     (out_en),
        .out_r      (out_r),
        .out_g      (out_g),
        .out_b      (out_b),
        .out_src    (out_src)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_layer(input int i, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        lay_r[8*i +: 8] = r;
        lay_g[8*i +: 8] = g;
        lay_b[8*i +: 8] = b;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick(1);
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    function automatic logic [27:0] pix();
        return {out_en, out_src, out_r, out_g, out_b};
    endfunction

    function automatic logic [27:0] mkpix(input logic en, input logic [2:0] src,
                                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {en, src, r, g, b};
    endfunction

    task automatic test_reset();
        logic [7:0] exp_rd [4];
        logic [27:0] exp_p;
        exp_rd = '{8'h0F, 8'hE4, 8'hFF, 8'h00};
        tick(3);
        exp_p = '0;
        n_cmp++;
        if (pix() !== exp_p) begin
            n_bad++;
            $display("FAIL reset_out: got %h want %h", pix(), exp_p);
        end
        n_cmp++;
        if (cfg_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_pending: got %b want 0", cfg_pending);
        end
        rstb = 1'b1;
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a);
            tick(1);
            n_cmp++;
            if (cfg_rdata !== exp_rd[a]) begin
                n_bad++;
                $display("FAIL reset_rd%0d: got %h want %h", a, cfg_rdata, exp_rd[a]);
            end
        end
    endtask

    task automatic test_default();
        tick(2);
        n_cmp++;
        if (pix() !== mkpix(1, 0, 10, 20, 30)) begin
            n_bad++;
            $display("FAIL default_l0: got %h want %h", pix(), mkpix(1, 0, 10, 20, 30));
        end
    endtask

    task automatic test_prio();
        cfg_write(2'd1, 8'h1B);
        tick(2);
        n_cmp++;
        if (pix() !== mkpix(1, 0, 10, 20, 30)) begin
            n_bad++;
            $display("FAIL prio_before_apply: got %h want %h", pix(), mkpix(1, 0, 10, 20, 30));
        end
        n_cmp++;
        if (cfg_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL prio_pending_set: got %b want 1", cfg_pending);
        end
        n_cmp++;
        if (cfg_rdata !== 8'h1B) begin
            n_bad++;
            $display("FAIL prio_readback: got %h want 1b", cfg_rdata);
        end
        pulse_frame();
        tick(2);
        n_cmp++;
        if (pix() !== mkpix(1, 3, 40, 50, 60)) begin
            n_bad++;
            $display("FAIL prio_l3_wins: got %h want %h", pix(), mkpix(1, 3, 40, 50, 60));
        end
        n_cmp++;
        if (cfg_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_pending_clr: got %b want 0", cfg_pending);
        end
        lay_en = 4'b0111;
        tick(2);
        n_cmp++;
        if (pix() !== mkpix(1, 2, 7, 8, 9)) begin
            n_bad++;
            $display("FAIL prio_l2_next: got %h want %h", pix(), mkpix(1, 2, 7, 8, 9));
        end
        lay_en = 4'hF;
        cfg_write(2'd1, 8'hE4);
        pulse_frame();
    endtask

    task automatic test_bg();
        cfg_write(2'd0, 8'hF0);
        cfg_write(2'd3, 8'h40);
        pulse_frame();
        tick(2);
        n_cmp++;
        if (pix() !== mkpix(1, 4, 8'h40, 8'h40, 8'h40)) begin
            n_bad++;
            $display("FAIL bg_fill: got %h want %h", pix(), mkpix(1, 4, 8'h40, 8'h40, 8'h40));
        end
        cfg_addr = 2'd0;
        tick(1);
        n_cmp++;
        if (cfg_rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL enable_upper_ignored: got %h want 00", cfg_rdata);
        end
        h_c_en = 1'b0;
        tick(2);
        n_cmp++;
        if (pix() !== 28'h0) begin
            n_bad++;
            $display("FAIL blank: got %h want 0", pix());
        end
        h_c_en = 1'b1;
        cfg_write(2'd0, 8'h0F);
        cfg_write(2'd3, 8'h00);
        pulse_frame();
    endtask

    task automatic test_fade();
        set_layer(0, 200, 100, 255);
        cfg_write(2'd2, 8'h7F);
        pulse_frame();
        tick(2);
        n_cmp++;
        if (pix() !== mkpix(1, 0, 100, 50, 127)) begin
            n_bad++;
            $display("FAIL fade_7f: got %h want %h", pix(), mkpix(1, 0, 100, 50, 127));
        end
        cfg_write(2'd2, 8'h00);
        pulse_frame();
        tick(2);
        n_cmp++;
        if (pix() !== mkpix(1, 0, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL fade_00: got %h want %h", pix(), mkpix(1, 0, 0, 0, 0));
        end
    endtask

    task automatic test_same_cycle();
        cfg_write(2'd2, 8'hFF);
        pulse_frame();
        tick(2);
        n_cmp++;
        if (pix() !== mkpix(1, 0, 200, 100, 255)) begin
            n_bad++;
            $display("FAIL fade_ff: got %h want %h", pix(), mkpix(1, 0, 200, 100, 255));
        end
        cfg_we      = 1'b1;
        cfg_addr    = 2'd2;
        cfg_wdata   = 8'h00;
        frame_start = 1'b1;
        tick(1);
        cfg_we      = 1'b0;
        frame_start = 1'b0;
        tick(2);
        n_cmp++;
        if (pix() !== mkpix(1, 0, 200, 100, 255)) begin
            n_bad++;
            $display("FAIL collide_no_change: got %h want %h", pix(), mkpix(1, 0, 200, 100, 255));
        end
        n_cmp++;
        if (cfg_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL collide_pending: got %b want 1", cfg_pending);
        end
        pulse_frame();
        tick(2);
        n_cmp++;
        if (pix() !== mkpix(1, 0, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL collide_applied: got %h want %h", pix(), mkpix(1, 0, 0, 0, 0));
        end
        n_cmp++;
        if (cfg_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL collide_pending_clr: got %b want 0", cfg_pending);
        end
        cfg_write(2'd2, 8'hFF);
        pulse_frame();
        tick(2);
    endtask

    task automatic test_back_to_back();
        logic [7:0] v [4];
        logic [27:0] exp_p;
        v = '{8'd11, 8'd22, 8'd33, 8'd44};
        for (int i = 0; i < 4; i++) begin
            set_layer(0, v[i], v[i], v[i]);
            tick(1);
            exp_p = (i == 0) ? mkpix(1, 0, 200, 100, 255) : mkpix(1, 0, v[i-1], v[i-1], v[i-1]);
            n_cmp++;
            if (pix() !== exp_p) begin
                n_bad++;
                $display("FAIL stream%0d: got %h want %h", i, pix(), exp_p);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_rd [4];
        exp_rd = '{8'h0F, 8'hE4, 8'hFF, 8'h00};
        cfg_write(2'd3, 8'h55);
        rstb = 1'b0;
        #1;
        n_cmp++;
        if (pix() !== 28'h0) begin
            n_bad++;
            $display("FAIL midreset_out: got %h want 0", pix());
        end
        n_cmp++;
        if (cfg_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_pending: got %b want 0", cfg_pending);
        end
        tick(2);
        rstb = 1'b1;
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a);
            tick(1);
            n_cmp++;
            if (cfg_rdata !== exp_rd[a]) begin
                n_bad++;
                $display("FAIL midreset_rd%0d: got %h want %h", a, cfg_rdata, exp_rd[a]);
            end
        end
        n_cmp++;
        if (pix() !== mkpix(1, 0, 44, 44, 44)) begin
            n_bad++;
            $display("FAIL midreset_resume: got %h want %h", pix(), mkpix(1, 0, 44, 44, 44));
        end
    endtask

    initial begin
        rstb        = 1'b0;
        h_c_en      = 1'b1;
        frame_start = 1'b0;
        lay_en      = 4'hF;
        lay_r       = '0;
        lay_g       = '0;
        lay_b       = '0;
        cfg_we      = 1'b0;
        cfg_addr    = 2'd0;
        cfg_wdata   = 8'h00;
        set_layer(0, 10, 20, 30);
        set_layer(1, 1, 2, 3);
        set_layer(2, 7, 8, 9);
        set_layer(3, 40, 50, 60);

        test_reset();
        test_default();
        test_prio();
        test_bg();
        test_fade();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
